// File: rtl/dco_period_gen.sv
// dco_period_gen: digitally-controlled oscillator with dithered LOW-phase correction
//
// Ports:
//   Clock, nReset   rising-edge clock, asynchronous active-low reset
//   enable          run request; deasserting parks in IDLE once the current period ends
//   timeout         loop-lost pulse; clears correction state and restarts the period
//   period_int      base phase length P (each phase nominally P+1 cycles)
//   corr_valid/corr_ready  handshake for a signed integer+fractional LOW correction
//   corr_sign       0 lengthens LOW, 1 shortens LOW
//   corr_mag        integer correction magnitude
//   corr_frac       fractional correction magnitude (dithered via accumulator)
//   f_out           square-wave output, decoded from state only
//   period_done     one-cycle pulse on the last LOW cycle of each period
module dco_period_gen #(
  parameter int W    = 8,
  parameter int FRAC = 4
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            enable,
  input  logic            timeout,
  input  logic [W-1:0]    period_int,
  input  logic            corr_valid,
  output logic            corr_ready,
  input  logic            corr_sign,
  input  logic [W-1:0]    corr_mag,
  input  logic [FRAC-1:0] corr_frac,
  output logic            f_out,
  output logic            period_done
);
  localparam int CW = 1 + W + FRAC;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t          state_q, state_d;
  logic [W+1:0]    cnt_q, cnt_d;
  logic [W+1:0]    low_len_q, low_len_d;
  logic [W-1:0]    p_q, p_d;
  logic [FRAC-1:0] acc_q, acc_d;
  logic [CW-1:0]   act_q, act_d;
  logic [CW-1:0]   pcorr_q, pcorr_d;
  logic            pend_q, pend_d;
  logic            done_q, done_d;
  logic            hs, carry, hi_end, lo_end;
  logic [CW-1:0]   eff;
  logic [FRAC-1:0] acc_sum;
  logic [W+2:0]    base, delta, len_s;
  logic [W+1:0]    len_clamped;
  always_comb begin
    hs = corr_valid && !pend_q;
    // A pending correction is promoted at HIGH->LOW, so that transition already uses it
    eff = pend_q ? pcorr_q : act_q;
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, eff[FRAC-1:0]};
    base = {3'b000, p_q} + (W+3)'(1);
    delta = {3'b000, eff[W+FRAC-1:FRAC]} + (W+3)'(carry);
    len_s = eff[W+FRAC] ? base - delta : base + delta;
    // Non-positive results (sign bit set or zero) clamp to a single LOW cycle
    len_clamped = (len_s[W+2] || len_s == '0) ? (W+2)'(1) : len_s[W+1:0];
    hi_end = state_q == HIGH && cnt_q == {2'b00, p_q};
    lo_end = state_q == LOW && cnt_q + (W+2)'(1) == low_len_q;
    state_d = state_q;
    cnt_d = cnt_q + (W+2)'(1);
    p_d = p_q;
    low_len_d = low_len_q;
    acc_d = acc_q;
    act_d = act_q;
    pend_d = pend_q;
    pcorr_d = pcorr_q;
    if (timeout) begin
      state_d = enable ? HIGH : IDLE;
      cnt_d = '0;
      p_d = enable ? period_int : p_q;
      acc_d = '0;
      act_d = '0;
      pend_d = 1'b0;
      pcorr_d = '0;
    end else begin
      if (state_q == IDLE && enable) begin
        state_d = HIGH;
        cnt_d = '0;
        p_d = period_int;
      end
      if (hi_end) begin
        state_d = LOW;
        cnt_d = '0;
        low_len_d = len_clamped;
        acc_d = acc_sum;
        act_d = eff;
        pend_d = 1'b0;
      end
      if (lo_end) begin
        state_d = enable ? HIGH : IDLE;
        cnt_d = '0;
        p_d = enable ? period_int : p_q;
      end
      // hs implies no pending entry, so it never collides with the promotion above
      if (hs) begin
        pend_d = 1'b1;
        pcorr_d = {corr_sign, corr_mag, corr_frac};
      end
    end
    // Registered pulse: raise it when the next cycle is the final LOW cycle
    done_d = state_d == LOW && cnt_d + (W+2)'(1) == low_len_d;
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      low_len_q <= '0;
      p_q <= '0;
      acc_q <= '0;
      act_q <= '0;
      pcorr_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      low_len_q <= low_len_d;
      p_q <= p_d;
      acc_q <= acc_d;
      act_q <= act_d;
      pcorr_q <= pcorr_d;
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end
  assign f_out = state_q == HIGH;
  assign period_done = done_q;
  assign corr_ready = !pend_q;
endmodule

// File: tb/tb_dco_period_gen.sv
// tb_dco_period_gen: directed and randomized checks of dco_period_gen against a phase-countdown model
module tb_dco_period_gen;
  localparam int W = 8;
  localparam int FRAC = 4;
  logic Clock = 1'b0;
  logic nReset = 1'b0;
  logic enable = 1'b0;
  logic timeout = 1'b0;
  logic [W-1:0] period_int = '0;
  logic corr_valid = 1'b0;
  logic corr_sign = 1'b0;
  logic [W-1:0] corr_mag = '0;
  logic [FRAC-1:0] corr_frac = '0;
  logic corr_ready, f_out, period_done;
  int n_checks = 0;
  int n_fail = 0;
  int m_phase, m_rem, m_p, m_acc;
  bit m_pv, m_done;
  int m_ps, m_pm, m_pf, m_as, m_am, m_af;

  dco_period_gen #(.W(W), .FRAC(FRAC)) dut (
    .Clock(Clock), .nReset(nReset), .enable(enable), .timeout(timeout),
    .period_int(period_int), .corr_valid(corr_valid), .corr_ready(corr_ready),
    .corr_sign(corr_sign), .corr_mag(corr_mag), .corr_frac(corr_frac),
    .f_out(f_out), .period_done(period_done)
  );

  always #5 Clock = ~Clock;

  function void model_reset();
    m_phase = 0; m_rem = 0; m_p = 0; m_acc = 0;
    m_pv = 0; m_done = 0;
    m_ps = 0; m_pm = 0; m_pf = 0; m_as = 0; m_am = 0; m_af = 0;
  endfunction

  function void start_high();
    m_phase = 1;
    m_p = int'(period_int);
    m_rem = m_p + 1;
  endfunction

  // Phase model: m_rem counts cycles left in the current phase, including this one
  function void model_step();
    bit hs;
    int c, len;
    hs = corr_valid && !m_pv;
    if (timeout) begin
      m_pv = 0; m_as = 0; m_am = 0; m_af = 0; m_acc = 0;
      if (enable) start_high(); else m_phase = 0;
    end else begin
      if (m_phase == 0) begin
        if (enable) start_high();
      end else if (m_phase == 1) begin
        if (m_rem == 1) begin
          if (m_pv) begin
            m_as = m_ps; m_am = m_pm; m_af = m_pf; m_pv = 0;
          end
          m_acc = m_acc + m_af;
          c = m_acc / (2 ** FRAC);
          m_acc = m_acc % (2 ** FRAC);
          len = m_p + 1 + (m_as != 0 ? -(m_am + c) : (m_am + c));
          if (len < 1) len = 1;
          m_phase = 2;
          m_rem = len;
        end else m_rem--;
      end else begin
        if (m_rem == 1) begin
          if (enable) start_high(); else m_phase = 0;
        end else m_rem--;
      end
      if (hs) begin
        m_pv = 1; m_ps = int'(corr_sign); m_pm = int'(corr_mag); m_pf = int'(corr_frac);
      end
    end
    m_done = m_phase == 2 && m_rem == 1;
  endfunction

  task automatic tick();
    @(posedge Clock);
    if (nReset) model_step();
    @(negedge Clock);
  endtask

  task automatic kick();
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
  endtask

  task automatic offer(input bit s, input int mag, input int frac);
    corr_valid = 1'b1;
    corr_sign = s;
    corr_mag = W'(mag);
    corr_frac = FRAC'(frac);
    tick();
    corr_valid = 1'b0;
  endtask

  // Counts HIGH cycles then LOW cycles up to and including the period_done cycle
  task automatic measure(output int hi, output int lo);
    int b;
    b = 0; hi = 0; lo = 1;
    while (!f_out && b < 600) begin tick(); b++; end
    while (f_out && b < 600) begin hi++; tick(); b++; end
    while (!period_done && b < 600) begin lo++; tick(); b++; end
    if (b >= 600) begin
      n_checks++; n_fail++;
      $display("FAIL measure_bound: got %0d cycles required < 600", b);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    @(negedge Clock);
    n_checks++; if (f_out !== 1'b0) begin n_fail++; $display("FAIL reset_f_out: got %b required 0", f_out); end
    n_checks++; if (period_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", period_done); end
    n_checks++; if (corr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", corr_ready); end
    nReset = 1'b1;
    model_reset();
    period_int = 8'd3;
    enable = 1'b1;
    tick();
    n_checks++; if (f_out !== 1'b1) begin n_fail++; $display("FAIL start_high: got %b required 1", f_out); end
    offer(1'b0, 1, 0);
    n_checks++; if (corr_ready !== 1'b0) begin n_fail++; $display("FAIL ready_after_hs: got %b required 0", corr_ready); end
    #2 nReset = 1'b0;
    #1;
    n_checks++; if (f_out !== 1'b0) begin n_fail++; $display("FAIL async_reset_f_out: got %b required 0", f_out); end
    n_checks++; if (corr_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b required 1", corr_ready); end
    @(negedge Clock);
    nReset = 1'b1;
    model_reset();
    tick();
    n_checks++; if (f_out !== 1'b1) begin n_fail++; $display("FAIL restart_high: got %b required 1", f_out); end
  endtask

  task automatic test_nominal();
    int hi, lo;
    for (int k = 0; k < 2; k++) begin
      measure(hi, lo);
      n_checks++; if (hi != 4) begin n_fail++; $display("FAIL nominal_high: got %0d required 4", hi); end
      n_checks++; if (lo != 4) begin n_fail++; $display("FAIL nominal_low: got %0d required 4", lo); end
    end
  endtask

  task automatic test_correction();
    int hi, lo;
    kick();
    offer(1'b0, 2, 0);
    n_checks++; if (corr_ready !== 1'b0) begin n_fail++; $display("FAIL corr_ready_low: got %b required 0", corr_ready); end
    measure(hi, lo);
    n_checks++; if (lo != 6) begin n_fail++; $display("FAIL corr_low_first: got %0d required 6", lo); end
    n_checks++; if (corr_ready !== 1'b1) begin n_fail++; $display("FAIL corr_ready_back: got %b required 1", corr_ready); end
    measure(hi, lo);
    n_checks++; if (hi != 4) begin n_fail++; $display("FAIL corr_high: got %0d required 4", hi); end
    n_checks++; if (lo != 6) begin n_fail++; $display("FAIL corr_low_persist: got %0d required 6", lo); end
  endtask

  task automatic test_clamp();
    int hi, lo;
    kick();
    offer(1'b1, 10, 0);
    measure(hi, lo);
    n_checks++; if (lo != 1) begin n_fail++; $display("FAIL clamp_low_first: got %0d required 1", lo); end
    measure(hi, lo);
    n_checks++; if (hi + lo != 5) begin n_fail++; $display("FAIL clamp_period: got %0d required 5", hi + lo); end
  endtask

  task automatic test_dither();
    int hi, lo, acc, exp_lo;
    int fr[2] = '{8, 4};
    foreach (fr[i]) begin
      kick();
      offer(1'b0, 0, fr[i]);
      acc = 0;
      for (int k = 0; k < 8; k++) begin
        measure(hi, lo);
        acc = acc + fr[i];
        exp_lo = 4 + (acc >= 16 ? 1 : 0);
        acc = acc % 16;
        n_checks++; if (lo != exp_lo) begin n_fail++; $display("FAIL dither_f%0d_p%0d: got %0d required %0d", fr[i], k, lo, exp_lo); end
      end
    end
  endtask

  task automatic test_timeout();
    int hi, lo;
    kick();
    for (int k = 0; k < 20 && f_out; k++) tick();
    offer(1'b0, 3, 0);
    n_checks++; if (corr_ready !== 1'b0) begin n_fail++; $display("FAIL to_pending: got %b required 0", corr_ready); end
    timeout = 1'b1;
    corr_valid = 1'b1;
    tick();
    timeout = 1'b0;
    corr_valid = 1'b0;
    n_checks++; if (f_out !== 1'b1) begin n_fail++; $display("FAIL to_f_out: got %b required 1", f_out); end
    n_checks++; if (corr_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b required 1", corr_ready); end
    n_checks++; if (period_done !== 1'b0) begin n_fail++; $display("FAIL to_done: got %b required 0", period_done); end
    measure(hi, lo);
    n_checks++; if (hi != 4) begin n_fail++; $display("FAIL to_high: got %0d required 4", hi); end
    n_checks++; if (lo != 4) begin n_fail++; $display("FAIL to_low: got %0d required 4", lo); end
  endtask

  task automatic test_enable_drop();
    int hi, lo;
    kick();
    enable = 1'b0;
    measure(hi, lo);
    n_checks++; if (hi != 4 || lo != 4) begin n_fail++; $display("FAIL drop_period: got %0d/%0d required 4/4", hi, lo); end
    tick();
    n_checks++; if (f_out !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %b required 0", f_out); end
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (f_out !== 1'b0 || period_done !== 1'b0) begin n_fail++; $display("FAIL drop_idle_hold: got %b%b required 00", f_out, period_done); end
    period_int = 8'd5;
    enable = 1'b1;
    tick();
    n_checks++; if (f_out !== 1'b1) begin n_fail++; $display("FAIL reenable_high: got %b required 1", f_out); end
    period_int = 8'd2;
    measure(hi, lo);
    n_checks++; if (hi != 6 || lo != 6) begin n_fail++; $display("FAIL reenable_period: got %0d/%0d required 6/6", hi, lo); end
    measure(hi, lo);
    n_checks++; if (hi != 3 || lo != 3) begin n_fail++; $display("FAIL new_period_int: got %0d/%0d required 3/3", hi, lo); end
  endtask

  task automatic test_random();
    @(negedge Clock);
    nReset = 1'b0;
    enable = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    model_reset();
    period_int = W'($urandom_range(0, 10));
    for (int k = 0; k < 4000; k++) begin
      enable = $urandom_range(0, 99) < 95;
      timeout = $urandom_range(0, 99) < 1;
      corr_valid = $urandom_range(0, 99) < 25;
      corr_sign = 1'($urandom_range(0, 1));
      corr_mag = $urandom_range(0, 99) < 10 ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
      corr_frac = FRAC'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 5) period_int = W'($urandom_range(0, 10));
      tick();
      n_checks++; if (f_out !== (m_phase == 1)) begin n_fail++; $display("FAIL rand_f_out@%0d: got %b required %b", k, f_out, m_phase == 1); end
      n_checks++; if (period_done !== m_done) begin n_fail++; $display("FAIL rand_done@%0d: got %b required %b", k, period_done, m_done); end
      n_checks++; if (corr_ready !== !m_pv) begin n_fail++; $display("FAIL rand_ready@%0d: got %b required %b", k, corr_ready, !m_pv); end
    end
    timeout = 1'b0;
    corr_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_correction();
    test_clamp();
    test_dither();
    test_timeout();
    test_enable_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dco_period_gen.md
# dco_period_gen

Parametrised digitally-controlled oscillator for the DPLL loop. It generates the square-wave output from a programmable base half-period. A signed integer-plus-fractional correction, accepted over a valid/ready handshake, stretches or shrinks the LOW phase; a fractional accumulator dithers the correction across periods. It sits between the phase-difference/loop-filter stage (correction source) and the DPLL feedback divider (consumer of `f_out` and `period_done`).

## Interface
- `W`, 8: width of the base half-period and correction magnitude.
- `FRAC`, 4: fractional correction bits (dither resolution 1/2^FRAC cycle per period).
- `Clock`  in  1  system clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; low parks the oscillator in IDLE after the current period.
- `timeout`  in  1  loop-lost pulse; clears correction state and restarts the period.
- `period_int`  in  W  base phase length P; each phase nominally lasts P+1 cycles.
- `corr_valid`  in  1  correction offered.
- `corr_ready`  out  1  correction slot free.
- `corr_sign`  in  1  0 = lengthen LOW, 1 = shorten LOW.
- `corr_mag`  in  W  integer correction magnitude.
- `corr_frac`  in  FRAC  fractional correction magnitude.
- `f_out`  out  1  oscillator output.
- `period_done`  out  1  one-cycle pulse on the last LOW cycle of each period.

## Operation
- FSM states: IDLE (f_out=0), HIGH (f_out=1), LOW (f_out=0). f_out is decoded from state only, so it is glitch-free.
- Transitions:
  - IDLE→HIGH when enable=1, with counter=0 and P_reg←period_int.
  - HIGH→LOW when counter==P_reg.
  - LOW→HIGH when counter==low_len-1 and enable=1; P_reg reloads from period_int.
  - LOW→IDLE when counter==low_len-1 and enable=0.
  - enable=0 never truncates a running period.
- Counter: W+2 bits. Zeroed on every state change; otherwise increments.
- Correction slot:
  - A handshake (corr_valid && corr_ready) loads a pending register {sign, mag, frac}.
  - corr_ready = !pending.
  - Pending is promoted to the active correction at the next HIGH→LOW transition, then cleared.
  - The active correction persists until replaced.
- Dither: at each HIGH→LOW transition, acc(FRAC bits) += active frac; carry c ∈ {0,1}. The accumulator wraps modulo 2^FRAC.
- LOW length:
  - low_len = P_reg+1 + (sign ? -(mag+c) : (mag+c)), computed in W+3-bit signed arithmetic.
  - Latched at the HIGH→LOW transition.
  - Clamped: if the result is <1, low_len=1. The maximum (2^W + 2^W) fits the counter without wrap.
- timeout:
  - Same-cycle effect: active correction, pending, and acc clear to 0; counter→0.
  - If enable=1, the state is forced to HIGH with P_reg reload; otherwise it goes to IDLE.
  - No period_done pulse.
  - timeout has priority over a simultaneous handshake; the offered correction is dropped and corr_ready reads 1 next cycle.
- period_int changes mid-period take effect only at the next HIGH entry.

## Timing
- Reset values: state=IDLE, f_out=0, period_done=0, corr_ready=1, counter/acc/correction/pending=0, P_reg=0.
- enable sampled high at edge t: f_out=1 from cycle t+1.
- HIGH lasts exactly P_reg+1 cycles. LOW lasts exactly low_len cycles. Period = P_reg+1+low_len.
- period_done is registered and asserted for the final LOW cycle only.
- Handshake accepted at edge t: corr_ready=0 from t+1 until the cycle after promotion. A correction accepted during LOW applies to the LOW of the following period, not the current one.
- Handshake in the same cycle as the HIGH→LOW transition: the transition uses the previous active correction; the new one is pending for the next period.
- Reset asserted mid-period: all outputs return to reset values immediately (asynchronous); restart follows the IDLE→HIGH rule.

## Test plan
- W=8, P=3, enable=1, no correction -> f_out high 4 cycles, low 4; period_done every 8 cycles on the last low cycle.
- Correction sign=0, mag=2, frac=0 accepted during HIGH -> LOW 6 cycles from that period onward; corr_ready low 1..4 cycles, then high.
- P=3, sign=1, mag=10 -> LOW clamped to 1 cycle; period 5.
- FRAC=4, sign=0, mag=0, frac=0x8 -> LOW lengths 4,5,4,5…; frac=0x4 -> 4,4,4,5 repeating.
- timeout mid-LOW with a pending correction -> next cycle f_out=1, counter=0, correction cleared, corr_ready=1, LOW back to 4; no period_done.
- enable dropped in HIGH -> period completes (period_done asserted), then IDLE with f_out=0; enable re-asserted -> HIGH one cycle later using the new period_int.
